clarvi_soc2_pll_ctrl: RTL and testbench

CLARVI_SOC2_PLL_CTRL -- requirements
Module: clarvi_soc2_pll_ctrl

---
 rtl/clarvi_soc2_pll_ctrl.sv | 144 ++++++++++++++
 tb/tb_clarvi_soc2_pll_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clarvi_soc2_pll_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the system reset; retries on lock timeout and latches a failure after too many.
module clarvi_soc2_pll_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_lost,
  output logic [7:0] relock_count,
  output logic       fail
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_ONE   = RW'(1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAILED    = 3'd4;

  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [RW-1:0] retries_r;
  logic [RW-1:0] retries_s;
  logic          sync_meta_r;
  logic          locked_sync_r;
  logic          lost_s;
  logic [7:0]    relock_s;

  // next-state, shared counter and retry/relock bookkeeping
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    retries_s = retries_r;
    lost_s    = 1'b0;
    relock_s  = relock_count;
    case (state_r)
      S_PLL_RESET: begin
        if (cnt_r == RST_LAST) begin
          state_s = S_WAIT_LOCK;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_sync_r) begin
          state_s = S_STABLE;
          cnt_s   = '0;
        end else if (cnt_r == WAIT_LAST) begin
          cnt_s     = '0;
          retries_s = retries_r + RETRY_ONE;
          if (retries_s == RETRY_LIMIT) begin
            state_s = S_FAILED;
          end else begin
            state_s = S_PLL_RESET;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_STABLE: begin
        // a dropout here is treated as a glitch: re-wait without resetting the PLL
        if (!locked_sync_r) begin
          state_s = S_WAIT_LOCK;
          cnt_s   = '0;
        end else if (cnt_r == STABLE_LAST) begin
          state_s   = S_RUN;
          cnt_s     = '0;
          retries_s = '0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!locked_sync_r) begin
          state_s = S_PLL_RESET;
          cnt_s   = '0;
          lost_s  = 1'b1;
          if (relock_count != 8'hFF) begin
            relock_s = relock_count + 8'd1;
          end else begin
            relock_s = relock_count;
          end
        end else begin
          state_s = S_RUN;
        end
      end
      S_FAILED: begin
        state_s = S_FAILED;
      end
      default: begin
        state_s = S_PLL_RESET;
        cnt_s   = '0;
      end
    endcase
  end

  // state, synchroniser and outputs registered from the next state
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_r       <= S_PLL_RESET;
      cnt_r         <= '0;
      retries_r     <= '0;
      sync_meta_r   <= 1'b0;
      locked_sync_r <= 1'b0;
      pll_rst       <= 1'b1;
      sys_reset_n   <= 1'b0;
      lock_lost     <= 1'b0;
      relock_count  <= 8'd0;
      fail          <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      retries_r     <= retries_s;
      sync_meta_r   <= pll_locked;
      locked_sync_r <= sync_meta_r;
      pll_rst       <= (state_s == S_PLL_RESET);
      sys_reset_n   <= (state_s == S_RUN);
      lock_lost     <= lost_s;
      relock_count  <= relock_s;
      fail          <= (state_s == S_FAILED);
    end
  end

endmodule

// File: tb/tb_clarvi_soc2_pll_ctrl.sv
// Scoreboard bench for clarvi_soc2_pll_ctrl: a phase-level reference model turns each
// pll_locked pattern into a per-cycle list of expected outputs that a monitor consumes.
module tb_clarvi_soc2_pll_ctrl;

  localparam int P    = 4;
  localparam int T    = 32;
  localparam int S    = 8;
  localparam int MAXR = 2;

  typedef struct packed {
    logic       pll_rst;
    logic       sys_n;
    logic       lost;
    logic [7:0] relock;
    logic       fail;
  } out_t;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_lost;
  logic [7:0] relock_count;
  logic       fail;

  int   n_tests;
  int   n_fail;
  out_t exp_q[$];
  out_t mon_exp;
  out_t mon_got;

  bit   lk[];
  out_t expv[];
  int   len_l;
  int   cyc;

  clarvi_soc2_pll_ctrl #(
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .lock_lost   (lock_lost),
    .relock_count(relock_count),
    .fail        (fail)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // synchronised lock as seen at edge e: the raw input two edges earlier
  function automatic bit ls(int e);
    if (e >= 2 && (e - 2) < lk.size()) return lk[e - 2];
    return 1'b0;
  endfunction

  function automatic void put(bit pr, bit sn, bit lo, int rc, bit fl);
    out_t o;
    o.pll_rst = pr;
    o.sys_n   = sn;
    o.lost    = lo;
    o.relock  = rc[7:0];
    o.fail    = fl;
    if (cyc <= len_l) expv[cyc] = o;
    cyc++;
  endfunction

  // expected outputs per cycle (cycle 0 = reset state), built phase by phase
  function automatic void build_model();
    int retries, relock;
    bit lost, got, locked_run;
    expv = new[len_l + 1];
    cyc = 0; retries = 0; relock = 0; lost = 1'b0;
    while (cyc <= len_l) begin
      for (int k = 0; k < P; k++) begin
        put(1'b1, 1'b0, lost, relock, 1'b0);
        lost = 1'b0;
      end
      locked_run = 1'b0;
      while (cyc <= len_l && !locked_run) begin
        got = 1'b0;
        for (int w = 0; w < T && !got; w++) begin
          put(1'b0, 1'b0, 1'b0, relock, 1'b0);
          got = ls(cyc - 1);
        end
        if (!got) break;
        locked_run = 1'b1;
        for (int n = 0; n < S; n++) begin
          put(1'b0, 1'b0, 1'b0, relock, 1'b0);
          if (!ls(cyc - 1)) begin
            locked_run = 1'b0;
            break;
          end
        end
      end
      if (!locked_run) begin
        retries++;
        if (retries == MAXR) begin
          while (cyc <= len_l) put(1'b0, 1'b0, 1'b0, relock, 1'b1);
        end
        continue;
      end
      retries = 0;
      while (cyc <= len_l) begin
        put(1'b0, 1'b1, 1'b0, relock, 1'b0);
        if (!ls(cyc - 1)) begin
          lost = 1'b1;
          if (relock < 255) relock++;
          break;
        end
      end
    end
  endfunction

  task automatic reset_cycle();
    out_t r;
    r.pll_rst = 1'b1; r.sys_n = 1'b0; r.lost = 1'b0; r.relock = 8'd0; r.fail = 1'b0;
    @(negedge refclk);
    rst_n      = 1'b0;
    pll_locked = 1'($urandom_range(1, 0));
    exp_q.push_back(r);
  endtask

  task automatic run_pattern();
    build_model();
    for (int c = 0; c < len_l; c++) begin
      @(negedge refclk);
      rst_n      = 1'b1;
      pll_locked = lk[c];
      exp_q.push_back(expv[c + 1]);
    end
  endtask

  // monitor: compare the DUT outputs just after each edge with the queued expectation
  always @(posedge refclk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = '{pll_rst, sys_reset_n, lock_lost, relock_count, fail};
      n_tests++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL outputs t=%0t got pll_rst=%0b sys_reset_n=%0b lock_lost=%0b relock=%0d fail=%0b want pll_rst=%0b sys_reset_n=%0b lock_lost=%0b relock=%0d fail=%0b",
                 $time, mon_got.pll_rst, mon_got.sys_n, mon_got.lost, mon_got.relock, mon_got.fail,
                 mon_exp.pll_rst, mon_exp.sys_n, mon_exp.lost, mon_exp.relock, mon_exp.fail);
      end
    end
  end

  initial begin
    int idx, rl;
    bit v;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; pll_locked = 1'b0;

    // locked from reset release; then cut off by reset mid-STABLE
    reset_cycle(); reset_cycle();
    len_l = 40; lk = new[len_l];
    foreach (lk[i]) lk[i] = 1'b1;
    run_pattern();
    reset_cycle();
    len_l = 9; lk = new[len_l];
    foreach (lk[i]) lk[i] = 1'b1;
    run_pattern();

    // never locks: two retries then FAILED, then reset out of FAILED
    reset_cycle();
    len_l = 90; lk = new[len_l];
    foreach (lk[i]) lk[i] = 1'b0;
    run_pattern();

    // 3-cycle glitch during STABLE
    reset_cycle();
    len_l = 40; lk = new[len_l];
    foreach (lk[i]) lk[i] = !(i >= 7 && i <= 9);
    run_pattern();

    // single lock loss in RUN
    reset_cycle();
    len_l = 60; lk = new[len_l];
    foreach (lk[i]) lk[i] = (i != 20);
    run_pattern();

    // 300 lock losses: relock_count saturates, lock_lost keeps pulsing
    reset_cycle();
    len_l = 20 + 300 * 20; lk = new[len_l];
    foreach (lk[i]) lk[i] = !(i >= 20 && (i % 20) == 0);
    run_pattern();

    // randomised lock waveforms
    for (int s = 0; s < 8; s++) begin
      reset_cycle();
      len_l = 400; lk = new[len_l];
      idx = 0;
      v = 1'($urandom_range(1, 0));
      while (idx < len_l) begin
        rl = v ? $urandom_range(60, 1) : ((s % 3 == 2) ? $urandom_range(120, 20) : $urandom_range(12, 1));
        for (int j = 0; j < rl && idx < len_l; j++) begin
          lk[idx] = v;
          idx++;
        end
        v = !v;
      end
      run_pattern();
    end

    reset_cycle();
    repeat (4) @(posedge refclk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
